// File: rtl/uart_fifo_pkg.sv
// Shared definitions for the FIFO-buffered UART: register map, CTRL layout,
// one-hot FSM encodings and small frame-format helpers.
package uart_fifo_pkg;

    localparam logic [7:0] REG_CTRL   = 8'h00;
    localparam logic [7:0] REG_STATUS = 8'h04;
    localparam logic [7:0] REG_BAUD   = 8'h08;
    localparam logic [7:0] REG_TXDATA = 8'h0C;
    localparam logic [7:0] REG_RXDATA = 8'h10;

    localparam int unsigned BAUD_W   = 16;
    localparam int unsigned BITCNT_W = 4;
    localparam logic [BAUD_W-1:0] BAUD_MIN = 16'd4;

    // CTRL register, MSB first (bit 10 down to bit 0)
    typedef struct packed {
        logic       ie_err;
        logic       ie_rx;
        logic       ie_txempty;
        logic       loopback;
        logic       stop2;
        logic [1:0] parity;
        logic [1:0] dbits;
        logic       rx_en;
        logic       tx_en;
    } ctrl_t;

    typedef enum logic [4:0] {
        TX_IDLE   = 5'b00001,
        TX_START  = 5'b00010,
        TX_DATA   = 5'b00100,
        TX_PARITY = 5'b01000,
        TX_STOP   = 5'b10000
    } tx_state_t;

    typedef enum logic [4:0] {
        RX_IDLE   = 5'b00001,
        RX_START  = 5'b00010,
        RX_DATA   = 5'b00100,
        RX_PARITY = 5'b01000,
        RX_STOP   = 5'b10000
    } rx_state_t;

    function automatic logic [7:0] dbits_mask(input logic [1:0] dbits);
        return 8'hFF >> (3'd3 - {1'b0, dbits});
    endfunction

    function automatic logic [BITCNT_W-1:0] last_bit_idx(input logic [1:0] dbits);
        return 4'd4 + {2'b00, dbits};
    endfunction

    function automatic logic parity_enabled(input logic [1:0] parity);
        return (parity == 2'b01) || (parity == 2'b10);
    endfunction

    // Even parity over the active data bits; odd is its inverse
    function automatic logic parity_bit(input logic [7:0] data, input logic [1:0] dbits,
                                        input logic odd);
        return (^(data & dbits_mask(dbits))) ^ odd;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers; push on full succeeds only
// when a pop happens in the same cycle.
module uart_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic [WIDTH-1:0]         head
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push_c;
    logic             do_pop_c;

    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count     = wr_ptr - rd_ptr;
    assign head      = mem[rd_ptr[AW-1:0]];
    assign do_pop_c  = pop && !empty;
    assign do_push_c = push && (!full || do_pop_c);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push_c) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop_c)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push_c) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/uart_fifo.sv
// Memory-mapped UART with TX/RX FIFOs, runtime frame format, sticky error
// flags and a registered level interrupt.
module uart_fifo
    import uart_fifo_pkg::*;
#(
    parameter logic [15:0] BAUD_DEFAULT = 16'h01B8,
    parameter int unsigned TX_DEPTH     = 8,
    parameter int unsigned RX_DEPTH     = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we_i,
    input  logic        re_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        tx_o,
    input  logic        rx_i,
    output logic        irq_o
);
    ctrl_t             ctrl;
    logic [BAUD_W-1:0] baud;
    logic rx_overrun, parity_err, frame_err, tx_overflow;

    logic [7:0] reg_addr_c;
    logic wr_ctrl_c, wr_status_c, wr_baud_c, wr_txdata_c, rd_rxdata_c;
    assign reg_addr_c  = addr_i[7:0];
    assign wr_ctrl_c   = we_i && (reg_addr_c == REG_CTRL);
    assign wr_status_c = we_i && (reg_addr_c == REG_STATUS);
    assign wr_baud_c   = we_i && (reg_addr_c == REG_BAUD);
    assign wr_txdata_c = we_i && (reg_addr_c == REG_TXDATA);
    assign rd_rxdata_c = re_i && (reg_addr_c == REG_RXDATA);

    logic                      tx_full_c, tx_empty_c, tx_start_c;
    logic [7:0]                tx_head_c;
    logic [$clog2(TX_DEPTH):0] tx_count_c;
    logic                      rx_full_c, rx_empty_c, rx_push_c, rx_pop_c;
    logic [7:0]                rx_head_c, rx_data;
    logic [$clog2(RX_DEPTH):0] rx_count_c;

    assign rx_pop_c = rd_rxdata_c && !rx_empty_c;

    uart_sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (wr_txdata_c && !tx_full_c),
        .pop   (tx_start_c),
        .din   (data_i[7:0]),
        .full  (tx_full_c),
        .empty (tx_empty_c),
        .count (tx_count_c),
        .head  (tx_head_c)
    );

    uart_sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rx_push_c),
        .pop   (rx_pop_c),
        .din   (rx_data),
        .full  (rx_full_c),
        .empty (rx_empty_c),
        .count (rx_count_c),
        .head  (rx_head_c)
    );

    // ---------------- transmitter ----------------
    tx_state_t           tx_state;
    logic [BAUD_W-1:0]   tx_cnt;
    logic [BITCNT_W-1:0] tx_bitcnt, tx_last;
    logic [7:0]          tx_shift;
    logic tx_par_en, tx_par_bit, tx_stop2, tx_stop_second;
    logic tx_bit_end_c, tx_frame_end_c, tx_busy_c;

    assign tx_bit_end_c   = (tx_cnt >= baud);
    assign tx_frame_end_c = (tx_state == TX_STOP) && tx_bit_end_c && (!tx_stop2 || tx_stop_second);
    // Back-to-back frames start straight out of the stop bit
    assign tx_start_c     = ctrl.tx_en && !tx_empty_c && ((tx_state == TX_IDLE) || tx_frame_end_c);
    assign tx_busy_c      = !tx_empty_c || (tx_state != TX_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state       <= TX_IDLE;
            tx_o           <= 1'b1;
            tx_cnt         <= '0;
            tx_bitcnt      <= '0;
            tx_last        <= '0;
            tx_shift       <= '0;
            tx_par_en      <= 1'b0;
            tx_par_bit     <= 1'b0;
            tx_stop2       <= 1'b0;
            tx_stop_second <= 1'b0;
        end else if (tx_start_c) begin
            tx_state       <= TX_START;
            tx_o           <= 1'b0;
            tx_cnt         <= '0;
            tx_shift       <= tx_head_c;
            tx_last        <= last_bit_idx(ctrl.dbits);
            tx_par_en      <= parity_enabled(ctrl.parity);
            tx_par_bit     <= parity_bit(tx_head_c, ctrl.dbits, ctrl.parity == 2'b10);
            tx_stop2       <= ctrl.stop2;
            tx_stop_second <= 1'b0;
        end else begin
            tx_cnt <= tx_bit_end_c ? '0 : tx_cnt + 16'd1;
            case (tx_state)
                TX_IDLE: begin
                    tx_o   <= 1'b1;
                    tx_cnt <= '0;
                end
                TX_START: if (tx_bit_end_c) begin
                    tx_state  <= TX_DATA;
                    tx_o      <= tx_shift[0];
                    tx_shift  <= tx_shift >> 1;
                    tx_bitcnt <= '0;
                end
                TX_DATA: if (tx_bit_end_c) begin
                    if (tx_bitcnt == tx_last) begin
                        tx_state <= tx_par_en ? TX_PARITY : TX_STOP;
                        tx_o     <= tx_par_en ? tx_par_bit : 1'b1;
                    end else begin
                        tx_bitcnt <= tx_bitcnt + 4'd1;
                        tx_o      <= tx_shift[0];
                        tx_shift  <= tx_shift >> 1;
                    end
                end
                TX_PARITY: if (tx_bit_end_c) begin
                    tx_state <= TX_STOP;
                    tx_o     <= 1'b1;
                end
                TX_STOP: if (tx_bit_end_c) begin
                    if (tx_stop2 && !tx_stop_second) tx_stop_second <= 1'b1;
                    else                             tx_state       <= TX_IDLE;
                end
                default: begin
                    tx_state <= TX_IDLE;
                    tx_o     <= 1'b1;
                end
            endcase
        end
    end

    // ---------------- receiver ----------------
    logic rx_s1, rx_s2, rx_prev;
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_s1   <= ctrl.loopback ? tx_o : rx_i;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
        end
    end

    rx_state_t           rx_state;
    logic [BAUD_W-1:0]   rx_cnt;
    logic [BITCNT_W-1:0] rx_bitcnt;
    logic [1:0]          rx_dbits;
    logic rx_par_en, rx_odd, rx_bit_end_c, rx_perr_set_c, rx_ferr_set_c;

    assign rx_bit_end_c  = (rx_cnt >= baud);
    assign rx_push_c     = ctrl.rx_en && (rx_state == RX_STOP) && rx_bit_end_c;
    assign rx_ferr_set_c = rx_push_c && !rx_s2;
    assign rx_perr_set_c = ctrl.rx_en && (rx_state == RX_PARITY) && rx_bit_end_c &&
                           (rx_s2 != parity_bit(rx_data, rx_dbits, rx_odd));

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state  <= RX_IDLE;
            rx_cnt    <= '0;
            rx_bitcnt <= '0;
            rx_data   <= '0;
            rx_dbits  <= '0;
            rx_par_en <= 1'b0;
            rx_odd    <= 1'b0;
        end else if (!ctrl.rx_en) begin
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
        end else begin
            case (rx_state)
                RX_IDLE: if (rx_prev && !rx_s2) begin
                    rx_state  <= RX_START;
                    rx_cnt    <= '0;
                    rx_data   <= '0;
                    rx_dbits  <= ctrl.dbits;
                    rx_par_en <= parity_enabled(ctrl.parity);
                    rx_odd    <= (ctrl.parity == 2'b10);
                end
                // Start bit is checked at mid-bit; a high level means a glitch
                RX_START: begin
                    if (rx_cnt >= (baud >> 1)) begin
                        rx_cnt    <= '0;
                        rx_bitcnt <= '0;
                        rx_state  <= rx_s2 ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_cnt <= rx_cnt + 16'd1;
                    end
                end
                RX_DATA: begin
                    rx_cnt <= rx_bit_end_c ? '0 : rx_cnt + 16'd1;
                    if (rx_bit_end_c) begin
                        rx_data[rx_bitcnt[2:0]] <= rx_s2;
                        if (rx_bitcnt == last_bit_idx(rx_dbits))
                            rx_state <= rx_par_en ? RX_PARITY : RX_STOP;
                        else
                            rx_bitcnt <= rx_bitcnt + 4'd1;
                    end
                end
                RX_PARITY: begin
                    rx_cnt <= rx_bit_end_c ? '0 : rx_cnt + 16'd1;
                    if (rx_bit_end_c) rx_state <= RX_STOP;
                end
                RX_STOP: begin
                    rx_cnt <= rx_bit_end_c ? '0 : rx_cnt + 16'd1;
                    if (rx_bit_end_c) rx_state <= RX_IDLE;
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    // ---------------- registers and interrupt ----------------
    logic [7:0] status_c;
    assign status_c = {tx_overflow, frame_err, parity_err, rx_overrun,
                       rx_full_c, tx_full_c, !rx_empty_c, tx_busy_c};

    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl        <= '0;
            baud        <= BAUD_DEFAULT;
            rx_overrun  <= 1'b0;
            parity_err  <= 1'b0;
            frame_err   <= 1'b0;
            tx_overflow <= 1'b0;
            irq_o       <= 1'b0;
        end else begin
            if (wr_ctrl_c) ctrl <= ctrl_t'(data_i[10:0]);
            if (wr_baud_c) baud <= (data_i[15:0] < BAUD_MIN) ? BAUD_MIN : data_i[15:0];
            // Set events take priority over a same-cycle write-one-to-clear
            rx_overrun  <= (rx_push_c && rx_full_c && !rx_pop_c) ||
                           (rx_overrun && !(wr_status_c && data_i[4]));
            parity_err  <= rx_perr_set_c || (parity_err && !(wr_status_c && data_i[5]));
            frame_err   <= rx_ferr_set_c || (frame_err && !(wr_status_c && data_i[6]));
            tx_overflow <= (wr_txdata_c && tx_full_c) ||
                           (tx_overflow && !(wr_status_c && data_i[7]));
            irq_o <= (ctrl.ie_txempty && !status_c[0]) || (ctrl.ie_rx && status_c[1]) ||
                     (ctrl.ie_err && (|status_c[7:4]));
        end
    end

    always_comb begin
        data_o = '0;
        case (reg_addr_c)
            REG_CTRL:   data_o = {21'h0, ctrl};
            REG_STATUS: data_o = {24'h0, status_c};
            REG_BAUD:   data_o = {16'h0, baud};
            REG_RXDATA: data_o = rx_empty_c ? '0 : {24'h0, rx_head_c & dbits_mask(ctrl.dbits)};
            default:    data_o = '0;
        endcase
    end

    logic unused_c;
    assign unused_c = ^{addr_i[31:8], data_i[31:16], tx_count_c, rx_count_c};

endmodule

// File: tb/tb_uart_fifo.sv
// Directed bench for uart_fifo: register reset values, loopback frames,
// 7E2 waveform, TX overflow, RX error flags and RX overrun interrupt.
module tb_uart_fifo;
    logic        clk = 1'b0;
    logic        rst, we_i, re_i, rx_i;
    logic [31:0] addr_i, data_i, data_o;
    logic        tx_o, irq_o;

    int n_vec  = 0;
    int n_miss = 0;
    int cyc    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_fifo #(.BAUD_DEFAULT(16'h01B8), .TX_DEPTH(8), .RX_DEPTH(8)) dut (
        .clk    (clk),
        .rst    (rst),
        .we_i   (we_i),
        .re_i   (re_i),
        .addr_i (addr_i),
        .data_i (data_i),
        .data_o (data_o),
        .tx_o   (tx_o),
        .rx_i   (rx_i),
        .irq_o  (irq_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        @(negedge clk);
        addr_i = {24'h0, a};
        data_i = d;
        we_i   = 1'b1;
        @(negedge clk);
        we_i   = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a, output logic [31:0] d);
        @(negedge clk);
        addr_i = {24'h0, a};
        re_i   = 1'b1;
        #1 d   = data_o;
        @(negedge clk);
        re_i   = 1'b0;
    endtask

    task automatic rd_check(input string tag, input logic [7:0] a, input logic [31:0] exp);
        logic [31:0] d;
        rd(a, d);
        check(tag, d, exp);
    endtask

    task automatic wait_tx_idle(input string tag);
        logic [31:0] s;
        s = 32'h1;
        for (int i = 0; i < 2000 && s[0]; i++) rd(8'h04, s);
        check(tag, {31'h0, s[0]}, 32'h0);
    endtask

    // One bit period is 16 clocks with BAUD=15
    task automatic send_rx(input logic [7:0] d, input int nbits, input logic par_en,
                           input logic par, input logic stop);
        @(negedge clk);
        rx_i = 1'b0;
        repeat (16) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            rx_i = d[i];
            repeat (16) @(negedge clk);
        end
        if (par_en) begin
            rx_i = par;
            repeat (16) @(negedge clk);
        end
        rx_i = stop;
        repeat (16) @(negedge clk);
        rx_i = 1'b1;
        repeat (16) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, n_vec=%0d", n_vec);
        $fatal(1);
    end

    initial begin
        int          t0;
        int          falls;
        logic        prev;
        logic        found;
        logic [10:0] exp_7e2;
        logic [7:0]  d9;

        rst = 1'b1; we_i = 1'b0; re_i = 1'b0; rx_i = 1'b1;
        addr_i = '0; data_i = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state
        rd_check("rst_baud", 8'h08, 32'h1B8);
        rd_check("rst_ctrl", 8'h00, 32'h0);
        rd_check("rst_status", 8'h04, 32'h0);
        check("rst_tx_o", {31'h0, tx_o}, 32'h1);
        check("rst_irq", {31'h0, irq_o}, 32'h0);

        // 8N1 loopback, two back-to-back frames
        wr(8'h08, 32'd15);
        rd_check("baud_15", 8'h08, 32'd15);
        wr(8'h08, 32'd2);
        rd_check("baud_min4", 8'h08, 32'd4);
        wr(8'h08, 32'd15);
        wr(8'h00, 32'h08F);
        wr(8'h0C, 32'h55);
        check("tx_lat_n1", {31'h0, tx_o}, 32'h1);
        @(posedge clk); #1;
        check("tx_lat_n2", {31'h0, tx_o}, 32'h0);
        t0 = cyc;
        wr(8'h0C, 32'hA3);
        while (cyc != t0 + 159) begin @(posedge clk); #1; end
        check("frame0_stop", {31'h0, tx_o}, 32'h1);
        @(posedge clk); #1;
        check("frame1_start_160", {31'h0, tx_o}, 32'h0);
        wait_tx_idle("idle_8n1");
        rd_check("lb_byte0", 8'h10, 32'h55);
        rd_check("lb_byte1", 8'h10, 32'hA3);
        rd_check("lb_status", 8'h04, 32'h0);
        rd_check("rx_empty_read", 8'h10, 32'h0);

        // 7E2 waveform: start, seven ones, parity 1, two stop bits
        wr(8'h00, 32'h0DB);
        wr(8'h0C, 32'h7F);
        @(posedge clk); #1;
        exp_7e2 = 11'b111_1111_1110;
        for (int k = 0; k < 11; k++) begin
            repeat ((k == 0) ? 8 : 16) @(posedge clk);
            #1;
            check($sformatf("7e2_bit%0d", k), {31'h0, tx_o}, {31'h0, exp_7e2[k]});
        end
        wait_tx_idle("idle_7e2");
        rd_check("7e2_rx", 8'h10, 32'h7F);
        rd_check("7e2_status", 8'h04, 32'h0);

        // TX overflow with transmitter disabled, then drain
        wr(8'h00, 32'h00C);
        for (int i = 0; i < 10; i++) wr(8'h0C, 32'hFF);
        rd_check("ovf_status", 8'h04, 32'h85);
        check("ovf_tx_idle", {31'h0, tx_o}, 32'h1);
        wr(8'h00, 32'h00D);
        falls = 0;
        prev  = 1'b1;
        for (int c = 0; c < 1700; c++) begin
            @(posedge clk); #1;
            if (prev && !tx_o) falls++;
            prev = tx_o;
        end
        check("ovf_frames", 32'(falls), 32'd8);
        rd_check("ovf_after", 8'h04, 32'h80);
        wr(8'h04, 32'h80);
        rd_check("ovf_w1c", 8'h04, 32'h0);

        // RX errors on 8E1: bad parity, bad stop, then a short glitch
        wr(8'h00, 32'h01E);
        send_rx(8'h01, 8, 1'b1, 1'b0, 1'b1);
        rd_check("perr_status", 8'h04, 32'h22);
        send_rx(8'h03, 8, 1'b1, 1'b0, 1'b0);
        rd_check("ferr_status", 8'h04, 32'h62);
        @(negedge clk);
        rx_i = 1'b0;
        repeat (2) @(negedge clk);
        rx_i = 1'b1;
        repeat (40) @(negedge clk);
        rd_check("err_byte0", 8'h10, 32'h01);
        rd_check("err_byte1", 8'h10, 32'h03);
        rd_check("glitch_nopush", 8'h04, 32'h60);
        wr(8'h04, 32'h60);
        rd_check("err_w1c", 8'h04, 32'h0);

        // RX overrun with error interrupt enabled
        wr(8'h00, 32'h40E);
        check("irq_quiet", {31'h0, irq_o}, 32'h0);
        for (int i = 0; i < 8; i++) send_rx(8'(8'h10 + i), 8, 1'b0, 1'b0, 1'b1);
        rd_check("rx_full_status", 8'h04, 32'h0A);
        d9 = 8'h18;
        @(negedge clk);
        rx_i = 1'b0;
        repeat (16) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_i = d9[i];
            repeat (16) @(negedge clk);
        end
        rx_i   = 1'b1;
        addr_i = 32'h04;
        found  = 1'b0;
        for (int c = 0; c < 40 && !found; c++) begin
            @(posedge clk); #1;
            if (data_o[4]) found = 1'b1;
        end
        check("ovr_seen", {31'h0, found}, 32'h1);
        check("irq_same_cycle", {31'h0, irq_o}, 32'h0);
        @(posedge clk); #1;
        check("irq_next_cycle", {31'h0, irq_o}, 32'h1);
        repeat (16) @(negedge clk);
        for (int i = 0; i < 8; i++)
            rd_check($sformatf("ovr_byte%0d", i), 8'h10, 32'h10 + 32'(i));
        rd_check("ovr_status", 8'h04, 32'h10);
        check("irq_held", {31'h0, irq_o}, 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
